// File: rtl/multi_channel_capture.sv
// multi_channel_capture
//   Per-channel circular sample buffers for NCH ADC channels. While ARMED every
//   adc_data_ready strobe stores one sample per channel. A trigger freezes a
//   window of how_many samples per channel, offset of them taken before the
//   trigger. The window is then streamed out channel by channel, one word per
//   read_request.
//
//   Optional feature macro: CAPTURE_TEST_PATTERN_EN
//     When defined, the test_pattern input exists. While it is high, each write
//     stores (sample_count + c) for channel c instead of adc_data.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   adc_data_ready  one-cycle strobe, adc_data holds one new sample per channel
//   adc_data        NCH*DW packed samples, channel c at [c*DW +: DW]
//   trigger         level, only looked at while ARMED
//   how_many        window length per channel, latched at trigger
//   offset          pre-trigger samples in the window, latched at trigger
//   read_request    consumer can take one word this cycle
//   test_pattern    (CAPTURE_TEST_PATTERN_EN only) store the counter pattern
//   data_out        readout word, valid when data_valid is high
//   data_valid      data_out valid; follows a read_request by one cycle
//   data_chan       channel that data_out came from
//   busy            high whenever the block is not ARMED
//   done            one-cycle pulse in the cycle after the final word

// One channel's buffer: plain write port and a registered read port. The array
// itself is not reset; only the read register is.
module mcc_chan_buf #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

module multi_channel_capture #(
  parameter  int NCH        = 4,
  parameter  int DW         = 12,
  parameter  int DEPTH_LOG2 = 8,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adc_data_ready,
  input  logic [NCH*DW-1:0]     adc_data,
  input  logic                  trigger,
  input  logic [DEPTH_LOG2-1:0] how_many,
  input  logic [DEPTH_LOG2-1:0] offset,
  input  logic                  read_request,
`ifdef CAPTURE_TEST_PATTERN_EN
  input  logic                  test_pattern,
`endif
  output logic [DW-1:0]         data_out,
  output logic                  data_valid,
  output logic [CW-1:0]         data_chan,
  output logic                  busy,
  output logic                  done
);
  localparam int AW = DEPTH_LOG2;

  typedef enum logic [1:0] {ARMED, POST, READ} state_t;
  state_t state, state_nx;

  logic [AW-1:0] wp, trig_ptr, hm_lat, off_lat, post_cnt, rd_idx;
  logic [AW-1:0] post_init, rd_start, raddr;
  logic [CW-1:0] rd_chan;
  logic          issued_all;
  logic          wr_en, trig_fire, issue, last_idx;

  logic [NCH-1:0][DW-1:0] wdata;
  logic [NCH-1:0][DW-1:0] rdata;

  // Samples arriving during READ are dropped so the frozen window survives.
  assign wr_en     = adc_data_ready && (state != READ);
  // The done cycle is already ARMED, but a re-trigger is only allowed after it.
  assign trig_fire = (state == ARMED) && trigger && (how_many != '0) && !done;
  assign post_init = (how_many > offset) ? how_many - offset : '0;

  assign rd_start  = trig_ptr - off_lat;
  assign raddr     = rd_start + rd_idx;
  assign issue     = (state == READ) && read_request && !issued_all;
  assign last_idx  = (rd_idx == hm_lat - AW'(1));

  assign busy      = (state != ARMED);
  assign data_out  = rdata[data_chan];

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [DW-1:0] sample_count;

  always_ff @(posedge clk or posedge reset)
    if (reset)      sample_count <= '0;
    else if (wr_en) sample_count <= sample_count + DW'(1);
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_lane
`ifdef CAPTURE_TEST_PATTERN_EN
    assign wdata[c] = test_pattern ? sample_count + DW'(c) : adc_data[c*DW +: DW];
`else
    assign wdata[c] = adc_data[c*DW +: DW];
`endif
    // All lanes read the same address; data_chan picks the one to present.
    mcc_chan_buf #(.DW(DW), .AW(AW)) u_buf (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .waddr (wp),
      .wdata (wdata[c]),
      .re    (issue),
      .raddr (raddr),
      .rdata (rdata[c])
    );
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ARMED;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      // A write in the trigger cycle is the first post-trigger sample, so a
      // one-sample post section can be finished by that same write.
      ARMED: if (trig_fire)
               state_nx = ((post_init == '0) || (post_init == AW'(1) && wr_en)) ? READ : POST;
      POST:  if (wr_en && post_cnt == AW'(1)) state_nx = READ;
      // Last read was issued last cycle and its word is on the output now.
      READ:  if (issued_all) state_nx = ARMED;
      default: state_nx = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp         <= '0;
      trig_ptr   <= '0;
      hm_lat     <= '0;
      off_lat    <= '0;
      post_cnt   <= '0;
      rd_idx     <= '0;
      rd_chan    <= '0;
      issued_all <= 1'b0;
      data_valid <= 1'b0;
      data_chan  <= '0;
      done       <= 1'b0;
    end else begin
      done       <= (state == READ) && issued_all;
      data_valid <= issue;
      if (issue) data_chan <= rd_chan;

      if (wr_en) wp <= wp + AW'(1);

      if (trig_fire) begin
        trig_ptr   <= wp;
        hm_lat     <= how_many;
        off_lat    <= offset;
        post_cnt   <= (wr_en && post_init != '0) ? post_init - AW'(1) : post_init;
        rd_idx     <= '0;
        rd_chan    <= '0;
        issued_all <= 1'b0;
      end else if (state == POST && wr_en) begin
        post_cnt <= post_cnt - AW'(1);
      end

      if (issue) begin
        if (last_idx) begin
          rd_idx <= '0;
          if (rd_chan == CW'(NCH-1)) issued_all <= 1'b1;
          else                       rd_chan    <= rd_chan + CW'(1);
        end else begin
          rd_idx <= rd_idx + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_capture.sv
// Directed bench for multi_channel_capture with defaults NCH=4, DW=12,
// DEPTH_LOG2=8. Channel c sample n is ((c<<8)|n) truncated to 12 bits.
module tb_multi_channel_capture;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int AW  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              adc_data_ready = 1'b0;
  logic              trigger = 1'b0;
  logic              read_request = 1'b0;
  logic [NCH*DW-1:0] adc_data = '0;
  logic [AW-1:0]     how_many = '0;
  logic [AW-1:0]     offset = '0;
`ifdef CAPTURE_TEST_PATTERN_EN
  logic              test_pattern = 1'b0;
`endif
  logic [DW-1:0]     data_out;
  logic              data_valid;
  logic [1:0]        data_chan;
  logic              busy, done;

  int checks = 0;
  int failures = 0;

  multi_channel_capture #(.NCH(NCH), .DW(DW), .DEPTH_LOG2(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_data_ready (adc_data_ready),
    .adc_data       (adc_data),
    .trigger        (trigger),
    .how_many       (how_many),
    .offset         (offset),
    .read_request   (read_request),
`ifdef CAPTURE_TEST_PATTERN_EN
    .test_pattern   (test_pattern),
`endif
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_chan      (data_chan),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] pat(int n);
    logic [NCH*DW-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*DW +: DW] = DW'((c << 8) | n);
    return v;
  endfunction

  // mode 0: captured adc pattern starting at sample n0; mode 1: counter pattern
  function automatic logic [DW-1:0] expw(int mode, int c, int n0, int i);
    if (mode == 1) return DW'(c + i);
    return DW'((c << 8) | (n0 + i));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; adc_data_ready = 1'b0; trigger = 1'b0; read_request = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One strobe cycle followed by two idle cycles.
  task automatic strobe(int n, bit trig, bit exp_busy);
    adc_data = pat(n); adc_data_ready = 1'b1; trigger = trig;
    tick();
    adc_data_ready = 1'b0; trigger = 1'b0;
    if (trig) chk("busy_after_trig", busy, exp_busy);
    tick();
    tick();
  endtask

  task automatic capture(int n_first, int n_last, int n_trig);
    for (int n = n_first; n <= n_last; n++) strobe(n, n == n_trig, 1'b1);
  endtask

  task automatic read_window(string tag, int n0, int hm, int mode, bit toggle, bit noise);
    int  got = 0;
    int  total = hm * NCH;
    bit  seen = 1'b0;
    bit  last_dv = 1'b0;
    chk({tag, "_busy_pre"}, busy, 1);
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      read_request = toggle ? (cyc % 2 == 0) : 1'b1;
      if (noise) begin
        trigger = 1'b1;
        adc_data_ready = (cyc % 3 == 0);
        adc_data = pat(999);
      end
      tick();
      if (data_valid) begin
        chk({tag, "_dv_req"}, read_request, 1);
        if (got < total) begin
          chk({tag, "_chan"}, data_chan, got / hm);
          chk({tag, "_data"}, data_out, expw(mode, got / hm, n0, got % hm));
        end else begin
          chk({tag, "_extra_word"}, got, total - 1);
        end
        got++;
      end
      if (done) begin
        seen = 1'b1;
        chk({tag, "_count"}, got, total);
        chk({tag, "_done_after_last"}, last_dv, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
      end
      last_dv = data_valid;
    end
    read_request = 1'b0; trigger = 1'b0; adc_data_ready = 1'b0;
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_data_chan", data_chan, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // basic window, request held high: samples 16..23 per channel
    how_many = 8; offset = 4;
    capture(0, 23, 20);
    read_window("basic", 16, 8, 0, 1'b0, 1'b0);

    // same window with request toggled every cycle
    do_reset();
    how_many = 8; offset = 4;
    capture(0, 23, 20);
    read_window("toggle", 16, 8, 0, 1'b1, 1'b0);

    // offset larger than how_many: straight to READ, samples 10..12
    do_reset();
    how_many = 3; offset = 10;
    capture(0, 20, 20);
    read_window("no_post", 10, 3, 0, 1'b0, 1'b0);

    // write pointer wrapped: samples 295..304
    do_reset();
    how_many = 10; offset = 5;
    capture(0, 304, 300);
    read_window("wrap", 295, 10, 0, 1'b0, 1'b0);

    // trigger held and strobes during READ are ignored; wp stays at 24
    do_reset();
    how_many = 8; offset = 4;
    capture(0, 23, 20);
    read_window("noise", 16, 8, 0, 1'b0, 1'b1);
    how_many = 4; offset = 2;
    capture(24, 29, 28);
    read_window("resume", 26, 4, 0, 1'b0, 1'b0);

    // reset in the middle of a readout
    do_reset();
    how_many = 8; offset = 4;
    capture(0, 23, 20);
    read_request = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1; read_request = 1'b0;
    tick();
    chk("midrst_data_out", data_out, 0);
    chk("midrst_data_valid", data_valid, 0);
    chk("midrst_data_chan", data_chan, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    tick();
    // how_many == 0 trigger is ignored; its sample still lands at wp 0
    how_many = 0; offset = 2;
    strobe(0, 1'b1, 1'b0);
    how_many = 4; offset = 2;
    capture(1, 11, 10);
    read_window("after_rst", 8, 4, 0, 1'b0, 1'b0);

`ifdef CAPTURE_TEST_PATTERN_EN
    test_pattern = 1'b1;
    do_reset();
    how_many = 4; offset = 0;
    capture(0, 3, 0);
    read_window("tpat", 0, 4, 1, 1'b0, 1'b0);
    test_pattern = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
